// File: rtl/sme_pkg.sv
// Shared constants for the string-match engine: special pattern characters,
// buffer address widths and the scheduler state encoding.
package sme_pkg;

    localparam int STR_AW = 5;
    localparam int PAT_AW = 3;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PREP0 = 3'd1;
    localparam logic [2:0] ST_PREP1 = 3'd2;
    localparam logic [2:0] ST_ANCH  = 3'd3;
    localparam logic [2:0] ST_CMP   = 3'd4;
    localparam logic [2:0] ST_TAIL  = 3'd5;
    localparam logic [2:0] ST_NEXT  = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

endpackage

// File: rtl/sme_match_scheduler_if.sv
// Bundle between the buffer-load side and the match scheduler: control,
// buffer read addresses with their same-cycle data, and the result port.
interface sme_match_scheduler_if;
    import sme_pkg::*;

    logic              start;
    logic [5:0]        str_len;
    logic [3:0]        pat_len;
    logic [STR_AW-1:0] rd_sidx;
    logic [7:0]        str_char;
    logic [PAT_AW-1:0] rd_pidx;
    logic [7:0]        pat_char;
    logic              busy;
    logic              valid;
    logic              match;
    logic [STR_AW-1:0] match_index;

    // Environment side: loads buffers, kicks off a search, observes the result.
    modport master (
        output start, str_len, pat_len, str_char, pat_char,
        input  rd_sidx, rd_pidx, busy, valid, match, match_index
    );

    // Scheduler side.
    modport slave (
        input  start, str_len, pat_len, str_char, pat_char,
        output rd_sidx, rd_pidx, busy, valid, match, match_index
    );

endinterface

// File: rtl/sme_char_eq.sv
// Single character compare: a dot in the pattern matches any string char.
module sme_char_eq
    import sme_pkg::*;
(
    input  logic [7:0] p_char,
    input  logic [7:0] s_char,
    output logic       eq
);

    assign eq = (p_char == CH_DOT) || (p_char == s_char);

endmodule

// File: rtl/sme_match_scheduler.sv
// Match scheduler: walks the candidate start index over the stored string,
// issuing one buffer read per cycle, resolves '^' / '$' / '.' and reports
// the lowest matching start index.
module sme_match_scheduler
    import sme_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    sme_match_scheduler_if.slave bus
);

    logic [2:0]        state_q, state_d;
    logic [5:0]        s_q, s_d;
    logic [2:0]        k_q, k_d;
    logic              caret_q, caret_d;
    logic              dollar_q, dollar_d;
    logic [5:0]        body_len_q, body_len_d;
    logic [5:0]        str_len_q, str_len_d;
    logic [3:0]        pat_len_q, pat_len_d;
    logic              match_q, match_d;
    logic [STR_AW-1:0] match_index_q, match_index_d;

    logic [STR_AW-1:0] rd_sidx;
    logic [PAT_AW-1:0] rd_pidx;
    logic              chars_eq;
    logic              pat_len_ok;
    logic [PAT_AW-1:0] pat_last;
    logic [STR_AW-1:0] sidx_anch, sidx_cmp, sidx_tail;
    logic [5:0]        s_next, last_start;
    logic [2:0]        nxt;

    // After the body matched: a '$' needs a space read unless the body ends the string.
    function automatic logic [2:0] tail_state(input logic dollar, input logic [5:0] s,
                                              input logic [5:0] len, input logic [5:0] slen);
        if (dollar && ((s + len) < slen)) return ST_TAIL;
        return ST_DONE;
    endfunction

    // First state for candidate s; anchor/body steps that need no read are folded away.
    function automatic logic [2:0] entry_state(input logic caret, input logic dollar,
                                               input logic [5:0] s, input logic [5:0] len,
                                               input logic [5:0] slen);
        if (caret && (s != 6'd0)) return ST_ANCH;
        if (len != 6'd0) return ST_CMP;
        return tail_state(dollar, s, len, slen);
    endfunction

    sme_char_eq u_char_eq (
        .p_char (bus.pat_char),
        .s_char (bus.str_char),
        .eq     (chars_eq)
    );

    assign pat_len_ok = (pat_len_q != 4'd0) && (pat_len_q <= 4'd8);
    assign pat_last   = pat_len_q[PAT_AW-1:0] - 3'd1;
    assign sidx_anch  = s_q[STR_AW-1:0] - 5'd1;
    assign sidx_cmp   = s_q[STR_AW-1:0] + {2'b00, k_q};
    assign sidx_tail  = s_q[STR_AW-1:0] + body_len_q[STR_AW-1:0];
    assign s_next     = s_q + 6'd1;
    assign last_start = str_len_q - body_len_q;

    // Next-state, read-address and result computation for the search FSM.
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        k_d           = k_q;
        caret_d       = caret_q;
        dollar_d      = dollar_q;
        body_len_d    = body_len_q;
        str_len_d     = str_len_q;
        pat_len_d     = pat_len_q;
        match_d       = match_q;
        match_index_d = match_index_q;
        rd_sidx       = '0;
        rd_pidx       = '0;
        nxt           = ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    str_len_d = bus.str_len;
                    pat_len_d = bus.pat_len;
                    caret_d   = 1'b0;
                    dollar_d  = 1'b0;
                    s_d       = '0;
                    k_d       = '0;
                    state_d   = ST_PREP0;
                end
            end

            ST_PREP0: begin
                rd_pidx = '0;
                caret_d = pat_len_ok && (bus.pat_char == CH_CARET);
                state_d = ST_PREP1;
            end

            ST_PREP1: begin
                rd_pidx    = pat_last;
                dollar_d   = pat_len_ok && (bus.pat_char == CH_DOLLAR);
                body_len_d = {2'b00, pat_len_q} - {5'd0, caret_q} - {5'd0, dollar_d};
                s_d        = '0;
                k_d        = '0;
                if (!pat_len_ok || (body_len_d > str_len_q)) begin
                    match_d       = 1'b0;
                    match_index_d = '0;
                    state_d       = ST_DONE;
                end else begin
                    nxt     = entry_state(caret_q, dollar_d, 6'd0, body_len_d, str_len_q);
                    state_d = nxt;
                    if (nxt == ST_DONE) begin
                        match_d       = 1'b1;
                        match_index_d = '0;
                    end
                end
            end

            ST_ANCH: begin
                rd_sidx = sidx_anch;
                k_d     = '0;
                if (bus.str_char == CH_SPACE) begin
                    nxt     = entry_state(1'b0, dollar_q, s_q, body_len_q, str_len_q);
                    state_d = nxt;
                    if (nxt == ST_DONE) begin
                        match_d       = 1'b1;
                        match_index_d = s_q[STR_AW-1:0];
                    end
                end else begin
                    state_d = ST_NEXT;
                end
            end

            ST_CMP: begin
                rd_sidx = sidx_cmp;
                rd_pidx = k_q + {2'b00, caret_q};
                if (!chars_eq) begin
                    state_d = ST_NEXT;
                end else if ({3'b000, k_q} == (body_len_q - 6'd1)) begin
                    nxt     = tail_state(dollar_q, s_q, body_len_q, str_len_q);
                    state_d = nxt;
                    if (nxt == ST_DONE) begin
                        match_d       = 1'b1;
                        match_index_d = s_q[STR_AW-1:0];
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end

            ST_TAIL: begin
                rd_sidx = sidx_tail;
                if (bus.str_char == CH_SPACE) begin
                    match_d       = 1'b1;
                    match_index_d = s_q[STR_AW-1:0];
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                k_d = '0;
                if (s_next > last_start) begin
                    match_d       = 1'b0;
                    match_index_d = '0;
                    state_d       = ST_DONE;
                end else begin
                    s_d     = s_next;
                    nxt     = entry_state(caret_q, dollar_q, s_next, body_len_q, str_len_q);
                    state_d = nxt;
                    if (nxt == ST_DONE) begin
                        match_d       = 1'b1;
                        match_index_d = s_next[STR_AW-1:0];
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s_q           <= '0;
            k_q           <= '0;
            caret_q       <= 1'b0;
            dollar_q      <= 1'b0;
            body_len_q    <= '0;
            str_len_q     <= '0;
            pat_len_q     <= '0;
            match_q       <= 1'b0;
            match_index_q <= '0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            k_q           <= k_d;
            caret_q       <= caret_d;
            dollar_q      <= dollar_d;
            body_len_q    <= body_len_d;
            str_len_q     <= str_len_d;
            pat_len_q     <= pat_len_d;
            match_q       <= match_d;
            match_index_q <= match_index_d;
        end
    end

    assign bus.rd_sidx     = rd_sidx;
    assign bus.rd_pidx     = rd_pidx;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.valid       = (state_q == ST_DONE);
    assign bus.match       = match_q;
    assign bus.match_index = match_index_q;

endmodule
